// File: rtl/crashlog_seq_pkg.sv
// Shared encodings for the crashlog/NMI sequencer: trigger FSM states,
// trigger source codes and the bit layout of the pending/sticky vectors.
package crashlog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } trig_state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_GLB    = 2'd1,
        SRC_CATERR = 2'd2,
        SRC_BMC    = 2'd3
    } trig_src_e;

    // Pending and sticky vectors share this layout: {BMC, CATERR, GLB}
    localparam int STICKY_GLB    = 0;
    localparam int STICKY_CATERR = 1;
    localparam int STICKY_BMC    = 2;

    function automatic logic [2:0] grantMask(input logic [2:0] pend);
        logic [2:0] mask;
        mask = 3'b000;
        if (pend[STICKY_GLB])         mask[STICKY_GLB]    = 1'b1;
        else if (pend[STICKY_CATERR]) mask[STICKY_CATERR] = 1'b1;
        else if (pend[STICKY_BMC])    mask[STICKY_BMC]    = 1'b1;
        return mask;
    endfunction

    function automatic trig_src_e maskToSource(input logic [2:0] mask);
        trig_src_e src;
        case (mask)
            3'b001:  src = SRC_GLB;
            3'b010:  src = SRC_CATERR;
            3'b100:  src = SRC_BMC;
            default: src = SRC_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero so it can never wrap.
module seq_down_counter #(
    parameter int          CNT_W   = 10,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CNT_W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/crashlog_nmi_sequencer.sv
// Crashlog trigger arbiter, BMC NMI router/stretcher and CATERR filter.
// Optional delayed CATERR output is built when CATERR_DLY_EN is defined.
module crashlog_nmi_sequencer
    import crashlog_seq_pkg::*;
#(
    parameter int TRIG_PULSE_CYC = 8,
    parameter int TRIG_GAP_CYC   = 4,
    parameter int NMI_PULSE_CYC  = 4,
    parameter int CATERR_DLY_CYC = 1000,
    parameter int CNT_W          = 10
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iCpuCatErr_n,
    input  logic       iCatErrFilterEvent,
    input  logic       iFmBmcCrashLogTrig_n,
    input  logic       iFmGlbRstWarn_n,
    input  logic       iIrqBmcCpuNmi,
    input  logic       iBmcNmiPchEna,
    input  logic       iClrSts,
    output logic       oCpuCatErr_n,
    output logic       oFmPchCrashlogTrig_n,
    output logic [1:0] oTrigSrc,
    output logic [2:0] oSrcSticky,
    output logic       oCpuNmi,
    output logic       oIrqBmcPchNmi,
    output logic       oCpuCatErrDly_n
);

    if (((1 << CNT_W) <= TRIG_PULSE_CYC) || ((1 << CNT_W) <= TRIG_GAP_CYC) ||
        ((1 << CNT_W) <= NMI_PULSE_CYC)  || ((1 << CNT_W) <= CATERR_DLY_CYC)) begin : gCntWidthCheck
        $error("CNT_W too narrow for the configured cycle counts");
    end

    logic       wCatErr_n;
    logic [2:0] srcCur;
    logic [2:0] fallEdge;
    logic       nmiRise;

    logic       catErr_q;
    logic [2:0] srcPrev_q;
    logic       nmiPrev_q;
    logic       armed_q;

    assign wCatErr_n = iCatErrFilterEvent ? iCpuCatErr_n : 1'b1;
    assign srcCur    = {iFmBmcCrashLogTrig_n, wCatErr_n, iFmGlbRstWarn_n};

    // armed_q holds off edge detection for one cycle after reset so that a
    // level held through reset is absorbed into history instead of firing
    assign fallEdge = armed_q ? (srcPrev_q & ~srcCur) : 3'b000;
    assign nmiRise  = armed_q & iIrqBmcCpuNmi & ~nmiPrev_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            catErr_q  <= 1'b1;
            srcPrev_q <= 3'b111;
            nmiPrev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            catErr_q  <= wCatErr_n;
            srcPrev_q <= srcCur;
            nmiPrev_q <= iIrqBmcCpuNmi;
            armed_q   <= 1'b1;
        end
    end

    assign oCpuCatErr_n = catErr_q;

    trig_state_e      state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic             trigN_q, trigN_d;
    trig_src_e        trigSrc_q, trigSrc_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [2:0]       gMask;
    logic             trigLoad;
    logic [CNT_W-1:0] trigLoadVal;
    logic             trigDec;
    logic             trigZero;

    assign gMask = grantMask(pending_q);

    // A new edge on the source being granted stays pending, as does a
    // sticky set that coincides with a clear
    always_comb begin
        state_d     = state_q;
        pending_d   = (pending_q | fallEdge);
        trigN_d     = trigN_q;
        trigSrc_d   = trigSrc_q;
        sticky_d    = iClrSts ? 3'b000 : sticky_q;
        trigLoad    = 1'b0;
        trigLoadVal = '0;
        trigDec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 3'b000) begin
                    state_d     = ST_ASSERT;
                    pending_d   = (pending_q & ~gMask) | fallEdge;
                    trigN_d     = 1'b0;
                    trigSrc_d   = maskToSource(gMask);
                    sticky_d    = sticky_d | gMask;
                    trigLoad    = 1'b1;
                    trigLoadVal = CNT_W'(TRIG_PULSE_CYC - 1);
                end
            end
            ST_ASSERT: begin
                if (trigZero) begin
                    state_d     = ST_GAP;
                    trigN_d     = 1'b1;
                    trigSrc_d   = SRC_NONE;
                    trigLoad    = 1'b1;
                    trigLoadVal = CNT_W'(TRIG_GAP_CYC - 1);
                end else begin
                    trigDec = 1'b1;
                end
            end
            ST_GAP: begin
                if (trigZero) begin
                    state_d = ST_IDLE;
                end else begin
                    trigDec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'b000;
            trigN_q   <= 1'b1;
            trigSrc_q <= SRC_NONE;
            sticky_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            trigN_q   <= trigN_d;
            trigSrc_q <= trigSrc_d;
            sticky_q  <= sticky_d;
        end
    end

    seq_down_counter #(.CNT_W(CNT_W)) uTrigCnt (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .load_i    (trigLoad),
        .loadVal_i (trigLoadVal),
        .dec_i     (trigDec),
        .zero_o    (trigZero)
    );

    assign oFmPchCrashlogTrig_n = trigN_q;
    assign oTrigSrc             = trigSrc_q;
    assign oSrcSticky           = sticky_q;

    logic nmiActive_q;
    logic nmiSel_q;
    logic nmiLoad;
    logic nmiZero;

    // The route is latched at the start of a pulse and edges seen while a
    // pulse is running are discarded
    assign nmiLoad = nmiRise & ~nmiActive_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            nmiActive_q <= 1'b0;
            nmiSel_q    <= 1'b0;
        end else if (nmiLoad) begin
            nmiActive_q <= 1'b1;
            nmiSel_q    <= iBmcNmiPchEna;
        end else if (nmiActive_q && nmiZero) begin
            nmiActive_q <= 1'b0;
        end
    end

    seq_down_counter #(.CNT_W(CNT_W)) uNmiCnt (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .load_i    (nmiLoad),
        .loadVal_i (CNT_W'(NMI_PULSE_CYC - 1)),
        .dec_i     (nmiActive_q),
        .zero_o    (nmiZero)
    );

    assign oCpuNmi       = nmiActive_q & ~nmiSel_q;
    assign oIrqBmcPchNmi = nmiActive_q &  nmiSel_q;

`ifdef CATERR_DLY_EN
    logic dlyZero;
    logic catErrDly_q;

    // The counter is held at its full preload while CATERR is inactive, so
    // the output only asserts after an unbroken low of CATERR_DLY_CYC cycles
    seq_down_counter #(.CNT_W(CNT_W), .RST_VAL(CATERR_DLY_CYC - 1)) uDlyCnt (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .load_i    (wCatErr_n),
        .loadVal_i (CNT_W'(CATERR_DLY_CYC - 1)),
        .dec_i     (~wCatErr_n),
        .zero_o    (dlyZero)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            catErrDly_q <= 1'b1;
        end else begin
            catErrDly_q <= wCatErr_n | ~dlyZero;
        end
    end

    assign oCpuCatErrDly_n = catErrDly_q;
`else
    assign oCpuCatErrDly_n = 1'b1;
`endif

endmodule
